mem_ctrl: RTL

//   Responder side of the MEM-stage memory request interface: accepts one read or write
//   per handshake, sequences an asynchronous SRAM (CE/OE/WE, split data bus) with fixed

---
 rtl/mem_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Async SRAM responder for MEM-stage requests; optional UART MMIO at 0xBF00/0xBF01 via MEM_CTRL_UART_EN.
// Latency: read ready at N+1+RD_CYCLES, write ready at N+3+WE_CYCLES, MMIO ready at N+1.
// Backpressure: requester holds request until mem_ready_o; DONE always returns to IDLE.
module mem_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RAM_ADDR_W = 18,
    parameter int RD_CYCLES  = 2,
    parameter int WE_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_wdata_i,
    input  logic                  mem_re_i,
    input  logic                  mem_we_i,
    output logic [DATA_W-1:0]     mem_rdata_o,
    output logic                  mem_ready_o,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0]     ram_data_o,
    output logic                  ram_data_oe,
    input  logic [DATA_W-1:0]     ram_data_i,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n
`ifdef MEM_CTRL_UART_EN
    ,
    input  logic [7:0]            uart_rx_data_i,
    input  logic                  uart_rx_ready_i,
    input  logic                  uart_tx_idle_i,
    output logic [7:0]            uart_tx_data_o,
    output logic                  uart_tx_start_o,
    output logic                  uart_rx_ack_o
`endif
);

    localparam int CNT_MAX = (RD_CYCLES > WE_CYCLES) ? RD_CYCLES : WE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

`ifdef MEM_CTRL_UART_EN
    localparam logic [ADDR_W-1:0] UART_DATA_ADDR = ADDR_W'(16'hBF00);
    localparam logic [ADDR_W-1:0] UART_STAT_ADDR = ADDR_W'(16'hBF01);

    logic is_mmio;
    assign is_mmio = (mem_addr_i == UART_DATA_ADDR) || (mem_addr_i == UART_STAT_ADDR);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mem_rdata_o <= '0;
            mem_ready_o <= 1'b0;
            ram_addr_o  <= '0;
            ram_data_o  <= '0;
            ram_data_oe <= 1'b0;
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
`ifdef MEM_CTRL_UART_EN
            uart_tx_data_o  <= '0;
            uart_tx_start_o <= 1'b0;
            uart_rx_ack_o   <= 1'b0;
`endif
        end else begin
            mem_ready_o <= 1'b0;
`ifdef MEM_CTRL_UART_EN
            uart_tx_start_o <= 1'b0;
            uart_rx_ack_o   <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (mem_re_i || mem_we_i) begin
                        ram_addr_o <= RAM_ADDR_W'(mem_addr_i);
                        ram_data_o <= mem_wdata_i;
`ifdef MEM_CTRL_UART_EN
                        if (is_mmio) begin
                            // MMIO completes in one cycle; SRAM strobes are never touched
                            state       <= S_DONE;
                            mem_ready_o <= 1'b1;
                            if (mem_we_i) begin
                                if (mem_addr_i == UART_DATA_ADDR) begin
                                    uart_tx_data_o  <= mem_wdata_i[7:0];
                                    uart_tx_start_o <= 1'b1;
                                end
                            end else if (mem_addr_i == UART_DATA_ADDR) begin
                                mem_rdata_o   <= DATA_W'(uart_rx_data_i);
                                uart_rx_ack_o <= 1'b1;
                            end else begin
                                mem_rdata_o <= DATA_W'({uart_rx_ready_i, uart_tx_idle_i});
                            end
                        end else
`endif
                        if (mem_we_i) begin
                            state       <= S_WR_SETUP;
                            ram_ce_n    <= 1'b0;
                            ram_data_oe <= 1'b1;
                        end else begin
                            state    <= S_RD;
                            ram_ce_n <= 1'b0;
                            ram_oe_n <= 1'b0;
                        end
                    end
                end

                S_RD: begin
                    if (cnt == CNT_W'(RD_CYCLES - 1)) begin
                        mem_rdata_o <= ram_data_i;
                        mem_ready_o <= 1'b1;
                        ram_ce_n    <= 1'b1;
                        ram_oe_n    <= 1'b1;
                        cnt         <= '0;
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_WR_SETUP: begin
                    ram_we_n <= 1'b0;
                    cnt      <= '0;
                    state    <= S_WR_PULSE;
                end

                S_WR_PULSE: begin
                    if (cnt == CNT_W'(WE_CYCLES - 1)) begin
                        ram_we_n <= 1'b1;
                        cnt      <= '0;
                        state    <= S_WR_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_WR_HOLD: begin
                    mem_ready_o <= 1'b1;
                    ram_ce_n    <= 1'b1;
                    ram_data_oe <= 1'b0;
                    state       <= S_DONE;
                end

                // The requester advances on this edge, so IDLE never re-samples the finished request
                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
